// File: rtl/pipelined_barrel_shifter.sv
// ----------------------------------------------------------------------------
// pipelined_barrel_shifter
//
// Pipelined shift/rotate unit for the ALU execute path. The log2(WIDTH) mux
// layers (layer k moves the operand by 2^k when amount bit k is set) are
// spread across STAGES register stages. Each stage register holds partial
// data, the amount bits, op, word flag, tag and a valid bit.
//
// Ops (in_op): 000 SLL, 001 SRL, 010 SRA, 011 ROL, 100 ROR, others pass.
// Word mode (in_word=1): operate on the low WIDTH/2 bits with the amount
// taken mod WIDTH/2, then sign-extend bit WIDTH/2-1 into the upper half.
//
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   in_valid / in_ready    request handshake
//   in_data, in_amt        operand and shift/rotate amount
//   in_op, in_word, in_tag operation, word-mode flag, opaque sideband tag
//   out_valid / out_ready  result handshake
//   out_data, out_tag      result and the tag of the producing request
//
// Handshake: a transfer happens on a rising edge where valid && ready.
// Stage s advances when its register is empty or stage s+1 advances; the
// last stage advances when out_ready=1 or it is empty. in_ready is the
// advance signal of stage 0, so it depends combinationally on out_ready.
// A stalled output holds out_data/out_tag stable.
// ----------------------------------------------------------------------------
module pipelined_barrel_shifter #(
  parameter int WIDTH  = 64,
  parameter int STAGES = 2,
  parameter int TAG_W  = 5
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  input  logic [$clog2(WIDTH)-1:0]   in_amt,
  input  logic [2:0]                 in_op,
  input  logic                       in_word,
  input  logic [TAG_W-1:0]           in_tag,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic [TAG_W-1:0]           out_tag
);

  localparam int LOG  = $clog2(WIDTH);
  localparam int HALF = WIDTH / 2;

  localparam logic [2:0] OP_SLL = 3'b000;
  localparam logic [2:0] OP_SRL = 3'b001;
  localparam logic [2:0] OP_SRA = 3'b010;
  localparam logic [2:0] OP_ROL = 3'b011;
  localparam logic [2:0] OP_ROR = 3'b100;

  // One mux layer: move d by sh positions. In word mode only the low half
  // is touched; the upper half is overwritten by sign extension at the end.
  function automatic logic [WIDTH-1:0] layer_fn(input logic [WIDTH-1:0] d,
                                                input int sh,
                                                input logic [2:0] op,
                                                input logic word);
    logic [WIDTH-1:0]        f;
    logic signed [WIDTH-1:0] fs;
    logic [HALF-1:0]         h;
    logic [HALF-1:0]         hr;
    logic signed [HALF-1:0]  hs;
    f  = d;
    fs = d;
    h  = d[HALF-1:0];
    hs = d[HALF-1:0];
    hr = h;
    if (word) begin
      case (op)
        OP_SLL:  hr = h << sh;
        OP_SRL:  hr = h >> sh;
        OP_SRA:  hr = hs >>> sh;
        OP_ROL:  hr = (h << sh) | (h >> (HALF - sh));
        OP_ROR:  hr = (h >> sh) | (h << (HALF - sh));
        default: hr = h;
      endcase
      f = {d[WIDTH-1:HALF], hr};
    end else begin
      case (op)
        OP_SLL:  f = d << sh;
        OP_SRL:  f = d >> sh;
        OP_SRA:  f = fs >>> sh;
        OP_ROL:  f = (d << sh) | (d >> (WIDTH - sh));
        OP_ROR:  f = (d >> sh) | (d << (WIDTH - sh));
        default: f = d;
      endcase
    end
    return f;
  endfunction

  // All layers owned by stage s: layer k lives in stage floor(k*STAGES/LOG).
  function automatic logic [WIDTH-1:0] stage_fn(input logic [WIDTH-1:0] d,
                                                input logic [LOG-1:0] amt,
                                                input logic [2:0] op,
                                                input logic word,
                                                input int s);
    logic [WIDTH-1:0] x;
    x = d;
    for (int k = 0; k < LOG; k++) begin
      if (((k * STAGES) / LOG == s) && amt[k]) begin
        x = layer_fn(x, 1 << k, op, word);
      end
    end
    return x;
  endfunction

  // Stage registers
  logic [STAGES-1:0] r_valid;
  logic [WIDTH-1:0]  r_data [STAGES];
  logic [LOG-1:0]    r_amt  [STAGES];
  logic [2:0]        r_op   [STAGES];
  logic [STAGES-1:0] r_word;
  logic [TAG_W-1:0]  r_tag  [STAGES];

  // Stage inputs (port for stage 0, previous register otherwise) and results
  logic [STAGES-1:0] w_src_valid;
  logic [WIDTH-1:0]  w_src_data [STAGES];
  logic [LOG-1:0]    w_src_amt  [STAGES];
  logic [2:0]        w_src_op   [STAGES];
  logic [STAGES-1:0] w_src_word;
  logic [TAG_W-1:0]  w_src_tag  [STAGES];
  logic [WIDTH-1:0]  w_res      [STAGES];
  logic [STAGES:0]   w_adv;

  always_comb begin
    w_src_valid[0] = in_valid;
    w_src_data[0]  = in_data;
    // Word mode drops the amount MSB so the shift is taken mod WIDTH/2.
    w_src_amt[0]   = in_word ? {1'b0, in_amt[LOG-2:0]} : in_amt;
    w_src_op[0]    = in_op;
    w_src_word[0]  = in_word;
    w_src_tag[0]   = in_tag;
    for (int s = 1; s < STAGES; s++) begin
      w_src_valid[s] = r_valid[s-1];
      w_src_data[s]  = r_data[s-1];
      w_src_amt[s]   = r_amt[s-1];
      w_src_op[s]    = r_op[s-1];
      w_src_word[s]  = r_word[s-1];
      w_src_tag[s]   = r_tag[s-1];
    end
    for (int s = 0; s < STAGES; s++) begin
      w_res[s] = stage_fn(w_src_data[s], w_src_amt[s], w_src_op[s], w_src_word[s], s);
    end
    // Word results (all ops, including pass-through) are sign-extended once
    // all layers have been applied.
    if (w_src_word[STAGES-1]) begin
      w_res[STAGES-1][WIDTH-1:HALF] = {HALF{w_res[STAGES-1][HALF-1]}};
    end
  end

  // Stall chain from the output back to the input; bubbles collapse because
  // an empty stage always advances.
  always_comb begin
    w_adv[STAGES] = out_ready;
    for (int s = STAGES - 1; s >= 0; s--) begin
      w_adv[s] = !r_valid[s] || w_adv[s+1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= '0;
      r_word  <= '0;
      for (int s = 0; s < STAGES; s++) begin
        r_data[s] <= '0;
        r_amt[s]  <= '0;
        r_op[s]   <= '0;
        r_tag[s]  <= '0;
      end
    end else begin
      for (int s = 0; s < STAGES; s++) begin
        if (w_adv[s]) begin
          r_valid[s] <= w_src_valid[s];
          // Payload only moves with a real request, keeping idle data quiet.
          if (w_src_valid[s]) begin
            r_data[s] <= w_res[s];
            r_amt[s]  <= w_src_amt[s];
            r_op[s]   <= w_src_op[s];
            r_word[s] <= w_src_word[s];
            r_tag[s]  <= w_src_tag[s];
          end
        end
      end
    end
  end

  assign in_ready  = w_adv[0];
  assign out_valid = r_valid[STAGES-1];
  assign out_data  = r_data[STAGES-1];
  assign out_tag   = r_tag[STAGES-1];

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// ----------------------------------------------------------------------------
// Bench for pipelined_barrel_shifter (WIDTH=64, STAGES=2, TAG_W=5).
// A negedge monitor pushes model results on every accepted request and pops
// them on every retired result; scenario tasks add their own inline checks.
// ----------------------------------------------------------------------------
module tb_pipelined_barrel_shifter;

  localparam int W  = 64;
  localparam int S  = 2;
  localparam int TW = 5;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic [5:0]    in_amt;
  logic [2:0]    in_op;
  logic          in_word;
  logic [TW-1:0] in_tag;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic [TW-1:0] out_tag;

  pipelined_barrel_shifter #(.WIDTH(W), .STAGES(S), .TAG_W(TW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_amt    (in_amt),
    .in_op     (in_op),
    .in_word   (in_word),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_tag   (out_tag)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int n_retired = 0;

  // ---------------- reference model ----------------
  function automatic logic [W-1:0] ref_shift(input logic [W-1:0] d, input logic [5:0] amt,
                                             input logic [2:0] op, input logic w);
    logic [127:0] t;
    logic [63:0]  r;
    logic [63:0]  hh;
    logic [31:0]  h;
    logic [31:0]  hr;
    int a;
    r = d;
    if (!w) begin
      a = int'(amt);
      case (op)
        3'd0: r = d << a;
        3'd1: r = d >> a;
        3'd2: r = $signed(d) >>> a;
        3'd3: begin t = {d, d} << a; r = t[127:64]; end
        3'd4: begin t = {d, d} >> a; r = t[63:0]; end
        default: r = d;
      endcase
    end else begin
      a = int'(amt) % 32;
      h = d[31:0];
      case (op)
        3'd0: hr = h << a;
        3'd1: hr = h >> a;
        3'd2: hr = $signed(h) >>> a;
        3'd3: begin hh = {h, h} << a; hr = hh[63:32]; end
        3'd4: begin hh = {h, h} >> a; hr = hh[31:0]; end
        default: hr = h;
      endcase
      r = {{32{hr[31]}}, hr};
    end
    return r;
  endfunction

  // ---------------- scoreboard / monitor ----------------
  logic [W+TW-1:0] exp_q[$];
  logic            mon_stall = 1'b0;
  logic [W-1:0]    stall_data;
  logic [TW-1:0]   stall_tag;

  always @(negedge clk) begin
    logic [W+TW-1:0] e;
    if (rst) begin
      mon_stall = 1'b0;
    end else begin
      if (mon_stall) begin
        n_vec++;
        if (out_valid !== 1'b1 || out_data !== stall_data || out_tag !== stall_tag) begin
          n_err++;
          $display("FAIL stall_hold: valid=%b data=%h tag=%0d required valid=1 data=%h tag=%0d",
                   out_valid, out_data, out_tag, stall_data, stall_tag);
        end
      end
      if (in_valid === 1'b1 && in_ready === 1'b1)
        exp_q.push_back({in_tag, ref_shift(in_data, in_amt, in_op, in_word)});
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        n_vec++;
        n_retired++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_output: tag=%0d data=%h required no output", out_tag, out_data);
        end else begin
          e = exp_q.pop_front();
          if ({out_tag, out_data} !== e) begin
            n_err++;
            $display("FAIL scoreboard: tag=%0d data=%h required tag=%0d data=%h",
                     out_tag, out_data, e[W+TW-1:W], e[W-1:0]);
          end
        end
      end
      mon_stall  = (out_valid === 1'b1) && (out_ready === 1'b0);
      stall_data = out_data;
      stall_tag  = out_tag;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_one(input logic [W-1:0] d, input logic [5:0] a, input logic [2:0] op,
                          input logic w, input logic [TW-1:0] tag,
                          output logic [W-1:0] res, output logic [TW-1:0] rtag, output int lat);
    res = '0;
    rtag = '0;
    lat = -1;
    @(posedge clk); #1;
    in_valid = 1'b1; in_data = d; in_amt = a; in_op = op; in_word = w; in_tag = tag;
    out_ready = 1'b1;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (in_ready === 1'b1) break;
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        lat = n; res = out_data; rtag = out_tag;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
  endtask

  task automatic drive_random_inputs(input logic [TW-1:0] tag);
    in_data = {$urandom, $urandom};
    in_amt  = 6'($urandom_range(0, 63));
    in_op   = 3'($urandom_range(0, 7));
    in_word = 1'($urandom_range(0, 1));
    in_tag  = tag;
  endtask

  // ---------------- scenario tasks ----------------
  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in_data = '0; in_amt = '0; in_op = '0; in_word = 1'b0; in_tag = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    n_vec += 4;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: %b required 0", out_valid); end
    if (out_data !== '0) begin n_err++; $display("FAIL reset_out_data: %h required 0", out_data); end
    if (out_tag !== '0) begin n_err++; $display("FAIL reset_out_tag: %0d required 0", out_tag); end
    if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: %b required 1", in_ready); end
  endtask

  typedef struct packed {
    logic [63:0] d;
    logic [5:0]  a;
    logic [2:0]  op;
    logic        w;
    logic [63:0] e;
  } vec_t;

  task automatic test_directed();
    vec_t tbl [13];
    logic [W-1:0]  res;
    logic [TW-1:0] rtag;
    int lat;
    tbl = '{
      '{64'h1, 6'd63, 3'd0, 1'b0, 64'h8000_0000_0000_0000},
      '{64'h1, 6'd0,  3'd0, 1'b0, 64'h1},
      '{64'h8000_0000_0000_0000, 6'd4, 3'd2, 1'b0, 64'hF800_0000_0000_0000},
      '{64'h8000_0000_0000_0000, 6'd4, 3'd1, 1'b0, 64'h0800_0000_0000_0000},
      '{64'h1, 6'd1, 3'd4, 1'b0, 64'h8000_0000_0000_0000},
      '{64'h8000_0000_0000_0000, 6'd1, 3'd3, 1'b0, 64'h1},
      '{64'h0123_4567_89AB_CDEF, 6'd32, 3'd3, 1'b0, 64'h89AB_CDEF_0123_4567},
      '{64'h1, 6'd31, 3'd0, 1'b1, 64'hFFFF_FFFF_8000_0000},
      '{64'hFFFF_FFFF_8000_0000, 6'd35, 3'd1, 1'b1, 64'h0000_0000_1000_0000},
      '{64'h0000_0000_8000_0000, 6'd4, 3'd2, 1'b1, 64'hFFFF_FFFF_F800_0000},
      '{64'h1, 6'd1, 3'd4, 1'b1, 64'hFFFF_FFFF_8000_0000},
      '{64'h1234_5678_9ABC_DEF0, 6'd9, 3'd5, 1'b1, 64'hFFFF_FFFF_9ABC_DEF0},
      '{64'h1234_5678_9ABC_DEF0, 6'd9, 3'd7, 1'b0, 64'h1234_5678_9ABC_DEF0}
    };
    for (int i = 0; i < 13; i++) begin
      send_one(tbl[i].d, tbl[i].a, tbl[i].op, tbl[i].w, TW'(i + 3), res, rtag, lat);
      n_vec += 3;
      if (res !== tbl[i].e) begin n_err++; $display("FAIL directed_data[%0d]: %h required %h", i, res, tbl[i].e); end
      if (rtag !== TW'(i + 3)) begin n_err++; $display("FAIL directed_tag[%0d]: %0d required %0d", i, rtag, i + 3); end
      if (lat !== S) begin n_err++; $display("FAIL directed_latency[%0d]: %0d required %0d", i, lat, S); end
    end
  endtask

  task automatic test_backpressure();
    int i, occ, r0;
    logic acc, ret, exp_rdy, saw_drop;
    i = 0; occ = 0; r0 = n_retired; saw_drop = 1'b0;
    @(posedge clk); #1;
    for (int c = 0; c < 40; c++) begin
      out_ready = !(c >= 3 && c <= 6);
      in_valid  = (i < 6);
      drive_random_inputs(TW'(i));
      @(negedge clk);
      // A collapsing pipe refuses input only when every stage is full and the
      // output is stalled.
      exp_rdy = !(occ == S && !out_ready);
      n_vec++;
      if (in_ready !== exp_rdy) begin
        n_err++; $display("FAIL bp_in_ready[c%0d]: %b required %b", c, in_ready, exp_rdy);
      end
      if (in_ready === 1'b0) saw_drop = 1'b1;
      acc = in_valid && in_ready;
      ret = out_valid && out_ready;
      occ = occ + int'(acc) - int'(ret);
      @(posedge clk); #1;
      if (acc) i++;
      if (i == 6 && occ == 0) break;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    n_vec += 2;
    if (n_retired - r0 !== 6) begin n_err++; $display("FAIL bp_count: %0d required 6", n_retired - r0); end
    if (saw_drop !== 1'b1) begin n_err++; $display("FAIL bp_ready_drop: %b required 1", saw_drop); end
  endtask

  task automatic test_random();
    logic acc;
    int t;
    t = 0; acc = 1'b1;
    @(posedge clk); #1;
    for (int c = 0; c < 400; c++) begin
      // Hold a request stable until it is accepted.
      if (!in_valid || acc) begin
        in_valid = ($urandom_range(0, 9) < 7);
        drive_random_inputs(TW'(t));
        if ($urandom_range(0, 3) == 0) in_amt = ($urandom_range(0, 1) == 1) ? 6'd63 : 6'd0;
        t++;
      end
      out_ready = ($urandom_range(0, 9) < 7);
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 20 && exp_q.size() != 0; c++) @(posedge clk);
    @(negedge clk);
    n_vec += 2;
    if (exp_q.size() !== 0) begin n_err++; $display("FAIL random_drain: %0d pending required 0", exp_q.size()); end
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL random_idle_valid: %b required 0", out_valid); end
  endtask

  task automatic test_mid_reset();
    logic [W-1:0]  res;
    logic [TW-1:0] rtag;
    int lat;
    @(posedge clk); #1;
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      drive_random_inputs(TW'(20 + i));
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    n_vec += 2;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL midrst_valid: %b required 0", out_valid); end
    if (in_ready !== 1'b1) begin n_err++; $display("FAIL midrst_in_ready: %b required 1", in_ready); end
    @(posedge clk); #1;
    out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_vec++;
      if (out_valid !== 1'b0) begin n_err++; $display("FAIL midrst_stale[%0d]: valid=%b required 0", c, out_valid); end
    end
    send_one(64'h5, 6'd3, 3'd0, 1'b0, TW'(9), res, rtag, lat);
    n_vec += 3;
    if (res !== 64'h28) begin n_err++; $display("FAIL midrst_data: %h required 28", res); end
    if (rtag !== TW'(9)) begin n_err++; $display("FAIL midrst_tag: %0d required 9", rtag); end
    if (lat !== S) begin n_err++; $display("FAIL midrst_latency: %0d required %0d", lat, S); end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_random();
    test_mid_reset();
    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
